tlc_phase_scheduler: RTL

Intersection right-of-way scheduler for the highway/country-road traffic light datapath, with a pedestrian walk phase added. It sequences highway, country and pedestrian phases using programmable green, yellow, all-red and walk durations. Country green is extended while cars are sensed, up to a maximum. It drives the 2-bit light codes to the signal heads and the walk lamp.

---
 rtl/tlc_phase_scheduler_pkg.sv | 21 ++
 rtl/tlc_phase_scheduler_phase_timer.sv | 27 ++
 rtl/tlc_phase_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tlc_phase_scheduler_pkg.sv
// Shared definitions for the traffic-light phase scheduler.
// Holds the 2-bit light codes driven to the signal heads and the 3-bit
// state encodings exported on the debug phase output.
package tlc_phase_scheduler_pkg;

  // Light codes. Code 2'd3 is never driven.
  localparam logic [1:0] LIGHT_GREEN  = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_RED    = 2'd2;

  // State encodings. These are kept as fixed constants because the values
  // are visible externally on the phase output.
  localparam logic [2:0] S_HG  = 3'd0;
  localparam logic [2:0] S_HY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_CG  = 3'd3;
  localparam logic [2:0] S_CY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;
  localparam logic [2:0] S_PW  = 3'd6;

endpackage

// File: rtl/tlc_phase_scheduler_phase_timer.sv
// phase_timer: saturating up-counter that measures time spent in the
// current phase.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-low reset (clears tcnt)
//   clr  - state-change strobe; clears tcnt on the edge that changes state
//   tcnt - cycles elapsed in the current phase, saturating at all-ones
module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] tcnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (clr) begin
      tcnt <= '0;
    end else if (tcnt != '1) begin
      tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: right-of-way scheduler for a highway/country-road
// intersection with a pedestrian walk phase.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous, active-low reset
//   x        - country-road car sensor (level)
//   ped_req  - pedestrian button (pulse or level)
//   hwy      - highway light code
//   cntry    - country light code
//   walk     - pedestrian walk lamp
//   ped_wait - pedestrian request latched but not yet served
//   phase    - current state encoding (debug)
module tlc_phase_scheduler
  import tlc_phase_scheduler_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 6,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  // Configuration checks, evaluated at elaboration.
  if (MIN_GREEN < 1 || MAX_GREEN < 1 || YELLOW < 1 || ALL_RED < 1 || WALK < 1)
  begin : g_bad_duration
    $error("tlc_phase_scheduler: all durations must be >= 1");
  end
  if (MAX_GREEN < MIN_GREEN) begin : g_bad_green
    $error("tlc_phase_scheduler: MAX_GREEN must be >= MIN_GREEN");
  end
  if (MAX_GREEN - 1 > (2 ** CNT_W) - 1 || YELLOW - 1 > (2 ** CNT_W) - 1 ||
      ALL_RED - 1 > (2 ** CNT_W) - 1 || WALK - 1 > (2 ** CNT_W) - 1)
  begin : g_bad_width
    $error("tlc_phase_scheduler: CNT_W too narrow for configured durations");
  end

  // A dwell of N cycles ends on the edge where tcnt == N-1.
  localparam logic [CNT_W-1:0] MING_END = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAXG_END = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             state_chg;
  logic             ped_pend;
  logic [CNT_W-1:0] tcnt;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_chg),
    .tcnt (tcnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_HG:  if (tcnt >= MING_END && (x || ped_pend)) state_nxt = S_HY;
      S_HY:  if (tcnt == YEL_END) state_nxt = S_AR1;
      // x may have dropped during HY; with nothing waiting the highway
      // simply returns to green.
      S_AR1: if (tcnt == AR_END) begin
               if (x)             state_nxt = S_CG;
               else if (ped_pend) state_nxt = S_PW;
               else               state_nxt = S_HG;
             end
      S_CG:  if ((tcnt >= MING_END && !x) || tcnt == MAXG_END) state_nxt = S_CY;
      S_CY:  if (tcnt == YEL_END) state_nxt = S_AR2;
      S_AR2: if (tcnt == AR_END) state_nxt = ped_pend ? S_PW : S_HG;
      S_PW:  if (tcnt == WALK_END) state_nxt = S_HG;
      default: state_nxt = S_HG;
    endcase
  end

  assign state_chg = (state_nxt != state);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_HG;
      ped_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      // Entering PW serves the request; that clear beats a same-edge press.
      if (state_nxt == S_PW && state != S_PW) begin
        ped_pend <= 1'b0;
      end else if (ped_req && state != S_PW) begin
        ped_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    hwy   = LIGHT_RED;
    cntry = LIGHT_RED;
    walk  = 1'b0;
    case (state)
      S_HG: hwy   = LIGHT_GREEN;
      S_HY: hwy   = LIGHT_YELLOW;
      S_CG: cntry = LIGHT_GREEN;
      S_CY: cntry = LIGHT_YELLOW;
      S_PW: walk  = 1'b1;
      default: ;
    endcase
  end

  assign ped_wait = ped_pend;
  assign phase    = state;

endmodule
